mem_req_sequencer: RTL and testbench

- Sits directly upstream of bus_controller, between the CPU core's memory/IO request path and the controller's mreq/mtype/mdone handshake.
- Buffers core requests in a small FIFO and issues them one at a time as clean mreq rising edges.
- Holds addr/data/mtype stable for the whole transaction and returns read data on a one-cycle response strobe.
- Enforces the mreq low-gap the controller's 2-flop edge detector needs, and flags hung or illegal transactions.

---
 rtl/mem_req_sequencer_pkg.sv | 27 ++
 rtl/mem_req_sequencer_req_fifo.sv | 58 +++++
 rtl/mem_req_sequencer.sv | 143 ++++++++++++++
 tb/tb_mem_req_sequencer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_req_sequencer_pkg.sv
// rtl/mem_req_sequencer_pkg.sv - shared mtype codes and request record for the request sequencer
package mem_req_sequencer_pkg;

    localparam logic [2:0] MT_RDATA = 3'd0;
    localparam logic [2:0] MT_WDATA = 3'd1;
    localparam logic [2:0] MT_RCHAR = 3'd2;
    localparam logic [2:0] MT_WCHAR = 3'd3;
    localparam logic [2:0] MT_PROGN = 3'd4;
    localparam logic [2:0] MT_PROGP = 3'd5;

    typedef struct packed {
        logic [2:0]  mtype;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } req_t;

    localparam int REQ_W = $bits(req_t);

    function automatic logic is_read_type(input logic [2:0] t);
        return (t == MT_RDATA) || (t == MT_RCHAR) || (t == MT_PROGN) || (t == MT_PROGP);
    endfunction

    function automatic logic is_legal_type(input logic [2:0] t);
        return t <= MT_PROGP;
    endfunction

endpackage

// File: rtl/mem_req_sequencer_req_fifo.sv
// rtl/mem_req_sequencer_req_fifo.sv - synchronous request FIFO with occupancy count
module req_fifo #(
    parameter int WIDTH = 27,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    // Full blocks the push even when a pop frees a slot on the same edge.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/mem_req_sequencer.sv
// rtl/mem_req_sequencer.sv - queues core memory requests and issues them as gapped mreq transactions
module mem_req_sequencer
    import mem_req_sequencer_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int GAP_CYCLES = 2,
    parameter int TIMEOUT    = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_type,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        busy,
    output logic [1:0]  err,
    output logic        mreq,
    output logic [2:0]  mtype,
    output logic [15:0] addr,
    output logic [7:0]  data_in,
    input  logic [7:0]  data_out,
    input  logic        mdone
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_GAP
    } state_e;

    state_e           state;
    state_e           state_next;
    logic [CNT_W-1:0] count;
    logic [REQ_W-1:0] head_bits;
    req_t             head;
    req_t             push_req;
    logic             push;
    logic             pop;
    logic             load;
    logic             complete;
    logic             illegal;
    logic [TO_W-1:0]  to_cnt;
    logic [GAP_W-1:0] gap_cnt;

    assign push_req  = '{mtype: req_type, addr: req_addr, wdata: req_wdata};
    assign head      = req_t'(head_bits);
    assign req_ready = (count < CNT_W'(DEPTH));
    assign push      = req_valid && req_ready;
    assign busy      = (count != '0) || (state != ST_IDLE);

    req_fifo #(
        .WIDTH (REQ_W),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (push_req),
        .rd_data (head_bits),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        load       = 1'b0;
        complete   = 1'b0;
        illegal    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (count != '0) begin
                    pop = 1'b1;
                    // Illegal codes are dropped here so they never reach the controller.
                    if (is_legal_type(head.mtype)) begin
                        load       = 1'b1;
                        state_next = ST_REQ;
                    end else begin
                        illegal = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (mdone) begin
                    complete   = 1'b1;
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_cnt == '0) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mreq      <= 1'b0;
            mtype     <= '0;
            addr      <= '0;
            data_in   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            err       <= '0;
            to_cnt    <= '0;
            gap_cnt   <= '0;
        end else begin
            rsp_valid <= complete;
            if (load) begin
                mreq    <= 1'b1;
                mtype   <= head.mtype;
                addr    <= head.addr;
                data_in <= head.wdata;
                to_cnt  <= '0;
            end
            if (complete) begin
                mreq    <= 1'b0;
                gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                if (is_read_type(mtype)) rsp_rdata <= data_out;
            end
            // Timeout only raises a flag; the transaction keeps waiting for mdone.
            if (state == ST_REQ && !mdone && to_cnt != TO_W'(TIMEOUT)) begin
                to_cnt <= to_cnt + TO_W'(1);
                if (to_cnt == TO_W'(TIMEOUT - 1)) err[0] <= 1'b1;
            end
            if (state == ST_GAP && gap_cnt != '0) gap_cnt <= gap_cnt - GAP_W'(1);
            if (illegal) err[1] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_req_sequencer.sv
// tb/tb_mem_req_sequencer.sv - scoreboard bench for mem_req_sequencer with a bus controller/slave model
module tb_mem_req_sequencer;
    import mem_req_sequencer_pkg::*;

    localparam int GAP = 2;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_type = '0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        busy;
    logic [1:0]  err;
    logic        mreq;
    logic [2:0]  mtype;
    logic [15:0] addr;
    logic [7:0]  data_in;
    logic [7:0]  data_out = '0;
    logic        mdone = 1'b0;

    int tests = 0;
    int fails = 0;
    logic [26:0] exp_iss[$];
    logic [7:0]  exp_rsp[$];
    logic [7:0]  bus_bytes[$];
    logic        ack_en = 1'b1;
    int          ack_delay = 2;

    mem_req_sequencer #(
        .DEPTH      (2),
        .GAP_CYCLES (GAP),
        .TIMEOUT    (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_type  (req_type),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .err       (err),
        .mreq      (mreq),
        .mtype     (mtype),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .mdone     (mdone)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] slave_byte(input logic [2:0] t, input logic [15:0] a);
        logic [7:0] lo;
        lo = a[7:0];
        case (t)
            MT_RDATA: return (a == 16'h1234) ? 8'hA5 : (lo ^ 8'h5A);
            MT_RCHAR: return 8'h0A;
            MT_PROGN: return 8'h77;
            MT_PROGP: return 8'h88;
            default:  return 8'hEE;
        endcase
    endfunction

    // Bus controller + slave: logs bytes moved per transaction, acks after ack_delay cycles.
    initial begin
        int  wcnt;
        logic pm;
        wcnt = 0;
        pm = 1'b0;
        forever begin
            @(negedge clk);
            if (mreq && !pm) begin
                if (mtype == MT_RDATA || mtype == MT_WDATA) begin
                    bus_bytes.push_back(addr[7:0]);
                    bus_bytes.push_back(addr[15:8]);
                end
                if (mtype == MT_WDATA || mtype == MT_WCHAR) bus_bytes.push_back(data_in);
            end
            pm = mreq;
            if (mdone) begin
                mdone = 1'b0;
            end else if (mreq && ack_en) begin
                wcnt++;
                if (wcnt >= ack_delay) begin
                    mdone = 1'b1;
                    data_out = slave_byte(mtype, addr);
                    wcnt = 0;
                end
            end else if (!mreq) begin
                wcnt = 0;
            end
        end
    end

    // Monitor: checks issue order/hold/gap and response data against the scoreboard queues.
    initial begin
        logic [26:0] lat;
        logic [26:0] e;
        logic [7:0]  r;
        int   low;
        logic pmq;
        lat = '0;
        low = 100;
        pmq = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                low = 100;
                pmq = 1'b0;
            end else begin
                if (mreq && !pmq) begin
                    check("gap_low_cycles_ok", 32'(low >= GAP + 1), 32'd1);
                    lat = {mtype, addr, data_in};
                    if (exp_iss.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_issue: got 0x%0h expected none", lat);
                    end else begin
                        e = exp_iss.pop_front();
                        check("issue", 32'(lat), 32'(e));
                    end
                end else if (mreq) begin
                    check("hold", 32'({mtype, addr, data_in}), 32'(lat));
                end
                low = mreq ? 0 : low + 1;
                pmq = mreq;
                if (rsp_valid) begin
                    if (exp_rsp.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_rsp: got 0x%0h expected none", rsp_rdata);
                    end else begin
                        r = exp_rsp.pop_front();
                        check("rsp_rdata", 32'(rsp_rdata), 32'(r));
                    end
                end
            end
        end
    end

    task automatic push(input logic [2:0] t, input logic [15:0] a, input logic [7:0] d,
                        input logic [7:0] rd, input bit legal);
        int n;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_type  = t;
        req_addr  = a;
        req_wdata = d;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL push_accept: got req_ready=0 expected 1 within 200 cycles");
        end else if (legal) begin
            exp_iss.push_back({t, a, d});
            exp_rsp.push_back(rd);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || exp_rsp.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy) + 32'(exp_rsp.size()), 32'd0);
    endtask

    task automatic wait_mreq(input string name);
        int n;
        n = 0;
        while (!mreq && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(mreq), 32'd1);
    endtask

    initial begin
        logic [7:0] expb [4];
        expb = '{8'hFF, 8'h00, 8'h3C, 8'h41};

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_outputs", 32'({mreq, mtype, addr, data_in, rsp_valid, rsp_rdata}), 32'd0);
        check("reset_status", 32'({busy, err, req_ready}), 32'd1);

        // Read into idle: latency, address, response
        push(MT_RDATA, 16'h1234, 8'h00, 8'hA5, 1'b1);
        @(negedge clk);
        check("t1_mreq_after_push_edge", 32'(mreq), 32'd0);
        @(negedge clk);
        check("t1_mreq_second_edge", 32'(mreq), 32'd1);
        check("t1_addr_type", 32'({mtype, addr}), 32'h0_1234);
        wait_idle("t1_drain");

        // Back-to-back writes: rsp_rdata keeps the last read byte
        bus_bytes.delete();
        push(MT_WDATA, 16'h00FF, 8'h3C, 8'hA5, 1'b1);
        push(MT_WCHAR, 16'h0000, 8'h41, 8'hA5, 1'b1);
        wait_idle("t2_drain");
        check("t2_bus_byte_count", 32'(bus_bytes.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < bus_bytes.size()) check("t2_bus_byte", 32'(bus_bytes[i]), 32'(expb[i]));
        end

        // Fill FIFO behind a stalled request
        ack_en = 1'b0;
        push(MT_RDATA, 16'h0010, 8'h00, 8'h4A, 1'b1);
        push(MT_RDATA, 16'h0020, 8'h00, 8'h7A, 1'b1);
        push(MT_PROGP, 16'h0000, 8'h00, 8'h88, 1'b1);
        @(negedge clk);
        check("t3_full_ready", 32'({req_ready, busy}), 32'd1);
        req_valid = 1'b1;
        req_type  = MT_WCHAR;
        req_wdata = 8'h99;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t3_third_not_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        ack_en = 1'b1;
        wait_idle("t3_drain");

        // Illegal type is dropped, following RCHAR issues
        push(3'd7, 16'h0BAD, 8'h00, 8'h00, 1'b0);
        push(MT_RCHAR, 16'h0000, 8'h00, 8'h0A, 1'b1);
        wait_idle("t4_drain");
        check("t4_err_illegal", 32'(err), 32'd2);

        // Timeout flag after TMO stalled cycles, then a late ack
        ack_en = 1'b0;
        push(MT_RDATA, 16'h0030, 8'h00, 8'h6A, 1'b1);
        wait_mreq("t5_mreq_up");
        repeat (TMO - 1) @(negedge clk);
        check("t5_err0_before", 32'(err[0]), 32'd0);
        @(negedge clk);
        check("t5_err0_set", 32'(err[0]), 32'd1);
        check("t5_mreq_held", 32'(mreq), 32'd1);
        ack_en = 1'b1;
        wait_idle("t5_drain");
        check("t5_err_both", 32'(err), 32'd3);

        // Reset during REQ aborts without a response
        ack_en = 1'b0;
        push(MT_PROGN, 16'h0000, 8'h00, 8'h77, 1'b1);
        wait_mreq("t6_mreq_up");
        @(posedge clk);
        #1 reset = 1'b1;
        exp_iss.delete();
        exp_rsp.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t6_after_reset", 32'({mreq, busy, err, rsp_valid}), 32'd0);
        ack_en = 1'b1;
        push(MT_PROGN, 16'h0000, 8'h00, 8'h77, 1'b1);
        wait_idle("t6_drain");

        check("final_issue_queue", 32'(exp_iss.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
